// File: rtl/aes_loader_pkg.sv
// rtl/aes_loader_pkg.sv - shared constants and issue FSM encoding for the AES block loader
package aes_loader_pkg;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_e;
endpackage

// File: rtl/aes_loader_slot.sv
// rtl/aes_loader_slot.sv - one 128-bit assembly slot: lane write, full flag, free, clear
// Zeroizes data on clear/free when AES_LOADER_ZEROIZE_EN is defined.
module aes_loader_slot
  import aes_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [1:0]         wr_lane,
  input  logic [31:0]        wr_data,
  input  logic               set_full,
  input  logic               free,
  output logic [BLOCK_W-1:0] data,
  output logic               full
);
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear) begin
      full_d = 1'b0;
`ifdef AES_LOADER_ZEROIZE_EN
      data_d = '0;
`endif
    end else begin
      // Lane 0 is the most significant word of the block.
      for (int l = 0; l < WORDS_PER_BLOCK; l++) begin
        if (wr_en && wr_lane == 2'(l)) data_d[BLOCK_W-32*(l+1) +: 32] = wr_data;
      end
      if (set_full) full_d = 1'b1;
      if (free) begin
        full_d = 1'b0;
`ifdef AES_LOADER_ZEROIZE_EN
        data_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;
endmodule

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - ping-pong word-to-block loader feeding the AES core
// Optional AES_LOADER_ZEROIZE_EN: scrub plaintext on clear/free and outside issue.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int BUSY_TIMEOUT = 15,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               core_ready,
  output logic               core_init,
  output logic [BLOCK_W-1:0] core_plaintext,
  output logic [CNT_W-1:0]   blocks_issued,
  output logic               partial_drop,
  output logic               timeout_err
);
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [1:0]         word_cnt_q, word_cnt_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BLOCK_W-1:0] core_plaintext_q, core_plaintext_d;
  logic [CNT_W-1:0]   blocks_issued_q, blocks_issued_d;
  logic               partial_drop_q, partial_drop_d;
  logic               timeout_err_q, timeout_err_d;

  logic [BLOCK_W-1:0] slot_data [2];
  logic [1:0]         slot_full, slot_wr, slot_set_full, slot_free;
  logic               accept, free_rd, show_live;

  assign in_ready  = !rst && !clear && !slot_full[wr_ptr_q];
  assign accept    = in_valid && in_ready;
  assign slot_free = {free_rd && rd_ptr_q, free_rd && !rd_ptr_q};
  assign show_live = (state_q == ISSUE) || (state_q == WAIT_LO);

  for (genvar i = 0; i < 2; i++) begin : g_slot
    aes_loader_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .wr_en    (slot_wr[i]),
      .wr_lane  (word_cnt_q),
      .wr_data  (in_data),
      .set_full (slot_set_full[i]),
      .free     (slot_free[i]),
      .data     (slot_data[i]),
      .full     (slot_full[i])
    );
  end

  always_comb begin
    word_cnt_d    = word_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    slot_wr       = '0;
    slot_set_full = '0;
    if (accept) begin
      slot_wr[wr_ptr_q] = 1'b1;
      word_cnt_d        = word_cnt_q + 2'd1;
      if (word_cnt_q == 2'(WORDS_PER_BLOCK - 1)) begin
        slot_set_full[wr_ptr_q] = 1'b1;
        wr_ptr_d                = !wr_ptr_q;
      end
    end
    if (clear) begin
      word_cnt_d = '0;
      wr_ptr_d   = 1'b0;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    rd_ptr_d        = rd_ptr_q;
    blocks_issued_d = blocks_issued_q;
    timeout_err_d   = timeout_err_q;
    core_init       = 1'b0;
    free_rd         = 1'b0;
    case (state_q)
      IDLE: if (slot_full[rd_ptr_q] && core_ready) state_d = ISSUE;
      ISSUE: begin
        core_init = 1'b1;
        timer_d   = '0;
        state_d   = WAIT_LO;
      end
      WAIT_LO: begin
        if (!core_ready) begin
          free_rd         = 1'b1;
          rd_ptr_d        = !rd_ptr_q;
          blocks_issued_d = blocks_issued_q + 1'b1;
          state_d         = WAIT_HI;
        end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
          // Slot stays full so the same block goes out again on the next pass.
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_HI: if (core_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d         = IDLE;
      rd_ptr_d        = 1'b0;
      core_init       = 1'b0;
      free_rd         = 1'b0;
      blocks_issued_d = blocks_issued_q;
    end
  end

  always_comb begin
    partial_drop_d = clear && (word_cnt_q != 2'd0);
`ifdef AES_LOADER_ZEROIZE_EN
    core_plaintext_d = '0;
`else
    core_plaintext_d = show_live ? slot_data[rd_ptr_q] : core_plaintext_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      word_cnt_q       <= '0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      timer_q          <= '0;
      core_plaintext_q <= '0;
      blocks_issued_q  <= '0;
      partial_drop_q   <= 1'b0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_cnt_q       <= word_cnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      timer_q          <= timer_d;
      core_plaintext_q <= core_plaintext_d;
      blocks_issued_q  <= blocks_issued_d;
      partial_drop_q   <= partial_drop_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign core_plaintext = show_live ? slot_data[rd_ptr_q] : core_plaintext_q;
  assign blocks_issued  = blocks_issued_q;
  assign partial_drop   = partial_drop_q;
  assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_aes_block_loader.sv
// tb/tb_aes_block_loader.sv - directed/random bench for aes_block_loader
// Reference: word queue -> block queue, core emulated by tasks.
module tb_aes_block_loader;
  logic         clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, core_ready = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready, core_init, partial_drop, timeout_err;
  logic [127:0] core_plaintext;
  logic [15:0]  blocks_issued;

  aes_block_loader dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .core_ready     (core_ready),
    .core_init      (core_init),
    .core_plaintext (core_plaintext),
    .blocks_issued  (blocks_issued),
    .partial_drop   (partial_drop),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, acc_cnt = 0, last_acc_cyc = 0, init_cyc = 0;
  logic [31:0]  pw[$];
  logic [127:0] exp_q[$];
  logic [15:0]  exp_cnt = '0;
  logic [127:0] last_blk = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic feed(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("feed_bound", 128'(n < 300), 128'(1));
    if (n >= 300) begin
      in_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;
    @(posedge clk);
    acc_cnt++;
    pw.push_back(w);
    if (pw.size() == 4) begin
      exp_q.push_back({pw[0], pw[1], pw[2], pw[3]});
      pw.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_init(output bit ok);
    int n = 0;
    while (!core_init && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok       = core_init;
    init_cyc = cyc;
    chk("init_seen", 128'(core_init), 128'(1));
  endtask

  // Core accepts the next block, dropping core_ready dly (>=1) cycles after init.
  task automatic serve(input int dly);
    bit ok;
    logic [127:0] blk;
    core_ready = 1'b1;
    wait_init(ok);
    if (!ok) return;
    blk = (exp_q.size() != 0) ? exp_q[0] : '1;
    chk("plaintext", core_plaintext, blk);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("init_pulse", 128'(core_init), 128'(0));
      chk("pt_hold", core_plaintext, blk);
    end
    core_ready = 1'b0;
    @(negedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_cnt++;
    last_blk = blk;
    chk("blocks_issued", 128'(blocks_issued), 128'(exp_cnt));
    core_ready = 1'b1;
  endtask

  initial begin
    bit ok;
    int n, base;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_init", 128'(core_init), 128'(0));
    chk("rst_pt", core_plaintext, 128'(0));
    chk("rst_cnt", 128'(blocks_issued), 128'(0));
    chk("rst_drop", 128'(partial_drop), 128'(0));
    chk("rst_terr", 128'(timeout_err), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // Single block with known words, latency check
    core_ready = 1'b1;
    feed(32'h00112233);
    feed(32'h44556677);
    feed(32'h8899aabb);
    feed(32'hccddeeff);
    chk("single_model", exp_q[0], 128'h00112233_44556677_8899aabb_ccddeeff);
    serve(2);
    chk("latency", 128'(init_cyc), 128'(last_acc_cyc + 2));
    chk("single_pt_held", core_plaintext, 128'h00112233_44556677_8899aabb_ccddeeff);

    // Backpressure: 12 random words with the core not ready
    core_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 12; i++) feed($urandom);
      end
      begin
        n = 0;
        while (acc_cnt < base + 8 && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (3) @(negedge clk);
        chk("bp_accepted", 128'(acc_cnt - base), 128'(8));
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        for (int b = 0; b < 3; b++) serve(int'($urandom_range(1, 4)));
      end
    join
    chk("bp_drained", 128'(exp_q.size() + pw.size()), 128'(0));

    // Timeout: core_ready stays high after init
    core_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed($urandom);
    wait_init(ok);
    repeat (14) @(negedge clk);
    chk("to_not_yet", 128'(timeout_err), 128'(0));
    repeat (3) @(negedge clk);
    chk("to_set", 128'(timeout_err), 128'(1));
    chk("to_cnt_same", 128'(blocks_issued), 128'(exp_cnt));
    serve(1);

    // Clear mid-block
    feed($urandom);
    feed($urandom);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    chk("clr_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    pw.delete();
    chk("clr_drop_pulse", 128'(partial_drop), 128'(1));
    @(negedge clk);
    chk("clr_drop_done", 128'(partial_drop), 128'(0));
    chk("clr_keeps_terr", 128'(timeout_err), 128'(1));
`ifdef AES_LOADER_ZEROIZE_EN
    chk("clr_pt_zero", core_plaintext, 128'(0));
`else
    chk("clr_pt_held", core_plaintext, last_blk);
`endif
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("clr_empty_nodrop", 128'(partial_drop), 128'(0));
    for (int i = 0; i < 4; i++) feed($urandom);
    serve(int'($urandom_range(1, 5)));

    // Clear during WAIT_LO
    for (int i = 0; i < 4; i++) feed($urandom);
    wait_init(ok);
    @(negedge clk);
    clear      = 1'b1;
    core_ready = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    pw.delete();
    chk("clrw_cnt", 128'(blocks_issued), 128'(exp_cnt));
    core_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= core_init;
    end
    chk("clrw_no_init", 128'(seen), 128'(0));

    // Reset mid-transfer
    core_ready = 1'b0;
    for (int i = 0; i < 5; i++) feed($urandom);
    rst = 1'b1;
    #1;
    chk("rstm_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    pw.delete();
    exp_q.delete();
    exp_cnt = '0;
    chk("rstm_cnt", 128'(blocks_issued), 128'(0));
    chk("rstm_terr", 128'(timeout_err), 128'(0));
    chk("rstm_pt", core_plaintext, 128'(0));
    rst        = 1'b0;
    core_ready = 1'b1;
    #1;
    chk("rstm_ready_back", 128'(in_ready), 128'(1));
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= core_init;
    end
    chk("rstm_no_init", 128'(seen), 128'(0));

    // Counter wrap
    force dut.blocks_issued_q = 16'hFFFF;
    @(negedge clk);
    release dut.blocks_issued_q;
    exp_cnt = 16'hFFFF;
    chk("wrap_preload", 128'(blocks_issued), 128'(exp_cnt));
    for (int i = 0; i < 4; i++) feed($urandom);
    serve(2);
    chk("wrap_zero", 128'(blocks_issued), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
